stack_param: RTL and testbench

- Parametrised LIFO stack; successor to the fixed 4-bit, 5-deep stack primitive.
- Accepts one command per clock: NOP, PUSH, POP, or GET (read the entry at depth INDEX below the top without popping).
- Adds configurable WIDTH/DEPTH, a selectable overflow mode (circular wrap or guarded), status flags, an occupancy count and an error pulse.
- Sits between a command sequencer and datapath logic as the stack-storage primitive.

---
 rtl/stack_pkg.sv | 14 +
 rtl/stack_param_if.sv | 30 +++
 rtl/stack_regfile.sv | 53 +++++
 rtl/stack_param.sv | 152 +++++++++++++++
 tb/tb_stack_param.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared command encoding and overflow-mode selectors for the parametrised stack.
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_t;

    localparam int MODE_WRAP  = 0;  // circular: overwrite oldest, underflow wraps
    localparam int MODE_GUARD = 1;  // boundary commands are rejected

endpackage

// File: rtl/stack_param_if.sv
// Command/response bundle between the sequencer (master) and the stack (slave).
interface stack_param_if
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    cmd_t              COMMAND;
    logic [AW-1:0]     INDEX;
    logic [WIDTH-1:0]  I_DATA;
    logic [WIDTH-1:0]  O_DATA;
    logic              O_VALID;
    logic [CW-1:0]     COUNT;
    logic              EMPTY;
    logic              FULL;
    logic              ERR;

    modport master (
        output COMMAND, INDEX, I_DATA,
        input  O_DATA, O_VALID, COUNT, EMPTY, FULL, ERR
    );

    modport slave (
        input  COMMAND, INDEX, I_DATA,
        output O_DATA, O_VALID, COUNT, EMPTY, FULL, ERR
    );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, one registered read port.
// The read register holds its value unless rd_en is set; rd_zero loads zero
// instead of memory so the controller can report "no such entry".
module stack_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic                      rd_zero,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]          rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic [WIDTH-1:0] rd_data_reg;

    // One-hot write decode, one select line per entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
        end
    endgenerate

    // Entry storage with synchronous clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (srst) begin
                mem[i] <= '0;
            end else if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Registered read port; holds between reads
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_zero ? '0 : mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack: TOP/COUNT bookkeeping, overflow-mode handling and
// status flags around a registered-read register file.
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int MODE  = MODE_WRAP
) (
    input  logic           CLK,
    input  logic           RESET,
    stack_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] top_reg,   top_next;
    logic [CW-1:0] count_reg, count_next;
    logic          valid_reg, valid_next;
    logic          err_reg,   err_next;
    logic          empty_reg, full_reg;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic          rd_zero;
    logic [AW-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;

    logic [AW-1:0] top_inc;
    logic [AW-1:0] top_dec;
    logic [AW:0]   get_sum;
    logic [AW-1:0] get_addr;
    logic          is_full;
    logic          is_empty;
    logic          idx_oob;
    logic          idx_beyond;

    // Modular pointer arithmetic and boundary detection
    always_comb begin
        top_inc    = (top_reg == AW'(DEPTH - 1)) ? '0 : top_reg + AW'(1);
        top_dec    = (top_reg == '0) ? AW'(DEPTH - 1) : top_reg - AW'(1);
        // TOP - INDEX mod DEPTH; only meaningful when INDEX < DEPTH
        get_sum    = {1'b0, top_reg} + (AW + 1)'(DEPTH) - {1'b0, bus.INDEX};
        get_addr   = (get_sum >= (AW + 1)'(DEPTH)) ? AW'(get_sum - (AW + 1)'(DEPTH))
                                                   : AW'(get_sum);
        is_full    = (count_reg == CW'(DEPTH));
        is_empty   = (count_reg == '0);
        idx_oob    = (int'(bus.INDEX) >= DEPTH);
        idx_beyond = (int'(bus.INDEX) >= int'(count_reg));
    end

    // Command decode: next pointer/count, storage strobes, response pulses
    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = top_inc;
        rd_en      = 1'b0;
        rd_zero    = 1'b0;
        rd_addr    = top_reg;

        case (bus.COMMAND)
            CMD_PUSH: begin
                if (is_full && MODE == MODE_GUARD) begin
                    err_next = 1'b1;
                end else begin
                    // In wrap mode a full push lands on the oldest entry
                    wr_en    = 1'b1;
                    top_next = top_inc;
                    err_next = is_full;
                    if (!is_full) begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            CMD_POP: begin
                if (is_empty && MODE == MODE_GUARD) begin
                    err_next = 1'b1;
                end else begin
                    // Entries are never cleared, so an empty wrap pop returns stale data
                    rd_en      = 1'b1;
                    rd_addr    = top_reg;
                    top_next   = top_dec;
                    valid_next = 1'b1;
                    err_next   = is_empty;
                    if (!is_empty) begin
                        count_next = count_reg - CW'(1);
                    end
                end
            end
            CMD_GET: begin
                rd_en      = 1'b1;
                valid_next = 1'b1;
                rd_addr    = get_addr;
                if (idx_oob) begin
                    rd_zero  = 1'b1;
                    err_next = 1'b1;
                end else if (idx_beyond) begin
                    rd_zero  = (MODE == MODE_GUARD);
                    err_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Control state and registered flags; reset discards the pending command
    always_ff @(posedge CLK) begin
        if (RESET) begin
            top_reg   <= AW'(DEPTH - 1);
            count_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
        end else begin
            top_reg   <= top_next;
            count_reg <= count_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CW'(DEPTH));
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (CLK),
        .srst    (RESET),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.I_DATA),
        .rd_en   (rd_en),
        .rd_zero (rd_zero),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.O_DATA  = rd_data;
    assign bus.O_VALID = valid_reg;
    assign bus.COUNT   = count_reg;
    assign bus.EMPTY   = empty_reg;
    assign bus.FULL    = full_reg;
    assign bus.ERR     = err_reg;

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: a WRAP and a GUARD instance receive identical commands;
// a reference model pushes expected responses into per-instance queues and a
// monitor pops and compares them after each clock edge.
module tb_stack_param;
    import stack_pkg::*;

    localparam int W  = 4;
    localparam int D  = 5;
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    typedef struct {
        int             due;
        logic           valid;
        logic [W-1:0]   data;
        int             count;
        logic           empty;
        logic           full;
        logic           err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    exp_t q_w[$];
    exp_t q_g[$];

    // Reference model state, index 0 = wrap, 1 = guard
    int m_mem [2][D];
    int m_top [2];
    int m_cnt [2];
    int m_od  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stack_param_if #(.WIDTH(W), .DEPTH(D)) bus_w ();
    stack_param_if #(.WIDTH(W), .DEPTH(D)) bus_g ();

    stack_param #(.WIDTH(W), .DEPTH(D), .MODE(MODE_WRAP)) dut_wrap (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_w)
    );

    stack_param #(.WIDTH(W), .DEPTH(D), .MODE(MODE_GUARD)) dut_guard (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_g)
    );

    // Stack semantics described as a circular array with a top pointer
    function automatic exp_t model_step(int m, bit r, int cmd, int idx, int din);
        exp_t e;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (r) begin
            for (int i = 0; i < D; i++) m_mem[m][i] = 0;
            m_top[m] = D - 1;
            m_cnt[m] = 0;
            m_od[m]  = 0;
        end else begin
            case (cmd)
                1: begin
                    if (m_cnt[m] == D && m == 1) begin
                        e.err = 1'b1;
                    end else begin
                        e.err = (m_cnt[m] == D);
                        m_top[m] = (m_top[m] + 1) % D;
                        m_mem[m][m_top[m]] = din;
                        if (m_cnt[m] < D) m_cnt[m]++;
                    end
                end
                2: begin
                    if (m_cnt[m] == 0 && m == 1) begin
                        e.err = 1'b1;
                    end else begin
                        e.err    = (m_cnt[m] == 0);
                        e.valid  = 1'b1;
                        m_od[m]  = m_mem[m][m_top[m]];
                        m_top[m] = (m_top[m] + D - 1) % D;
                        if (m_cnt[m] > 0) m_cnt[m]--;
                    end
                end
                3: begin
                    e.valid = 1'b1;
                    if (idx >= D) begin
                        m_od[m] = 0;
                        e.err   = 1'b1;
                    end else if (idx >= m_cnt[m]) begin
                        e.err   = 1'b1;
                        m_od[m] = (m == 1) ? 0 : m_mem[m][(m_top[m] - idx + D) % D];
                    end else begin
                        m_od[m] = m_mem[m][(m_top[m] - idx + D) % D];
                    end
                end
                default: ;
            endcase
        end
        e.data  = W'(m_od[m]);
        e.count = m_cnt[m];
        e.empty = (m_cnt[m] == 0);
        e.full  = (m_cnt[m] == D);
        e.due   = 0;
        return e;
    endfunction

    // Apply one command to both instances and queue the expected responses
    task automatic drive(bit r, int cmd, int idx, int din);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus_w.COMMAND = cmd_t'(cmd);
        bus_g.COMMAND = cmd_t'(cmd);
        bus_w.INDEX   = AW'(idx);
        bus_g.INDEX   = AW'(idx);
        bus_w.I_DATA  = W'(din);
        bus_g.I_DATA  = W'(din);
        e = model_step(0, r, cmd, idx, din);
        e.due = cyc + 1;
        q_w.push_back(e);
        e = model_step(1, r, cmd, idx, din);
        e.due = cyc + 1;
        q_g.push_back(e);
    endtask

    task automatic compare(string nm, exp_t e, logic v, logic [W-1:0] d,
                           logic [CW-1:0] c, logic em, logic fu, logic er);
        n_checks++;
        if (v !== e.valid || d !== e.data || int'(c) != e.count ||
            em !== e.empty || fu !== e.full || er !== e.err) begin
            $display("FAIL %s cyc=%0d got v=%0b d=%0d cnt=%0d empty=%0b full=%0b err=%0b want v=%0b d=%0d cnt=%0d empty=%0b full=%0b err=%0b",
                     nm, cyc, v, d, c, em, fu, er,
                     e.valid, e.data, e.count, e.empty, e.full, e.err);
        end else begin
            n_pass++;
            $display("ok   %s cyc=%0d v=%0b d=%0d cnt=%0d empty=%0b full=%0b err=%0b",
                     nm, cyc, v, d, c, em, fu, er);
        end
    endtask

    // Monitor: compare every response that is due after this clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q_w.size() > 0 && q_w[0].due < cyc) begin
                e = q_w.pop_front();
                n_checks++;
                $display("FAIL wrap_stale due=%0d now=%0d", e.due, cyc);
            end
            while (q_g.size() > 0 && q_g[0].due < cyc) begin
                e = q_g.pop_front();
                n_checks++;
                $display("FAIL guard_stale due=%0d now=%0d", e.due, cyc);
            end
            if (q_w.size() > 0 && q_w[0].due == cyc) begin
                e = q_w.pop_front();
                compare("wrap", e, bus_w.O_VALID, bus_w.O_DATA, bus_w.COUNT,
                        bus_w.EMPTY, bus_w.FULL, bus_w.ERR);
            end
            if (q_g.size() > 0 && q_g[0].due == cyc) begin
                e = q_g.pop_front();
                compare("guard", e, bus_g.O_VALID, bus_g.O_DATA, bus_g.COUNT,
                        bus_g.EMPTY, bus_g.FULL, bus_g.ERR);
            end
        end
    end

    // Stimulus: directed boundary sequences, then weighted random traffic
    initial begin
        int r, cmd, sel;
        bus_w.COMMAND = CMD_NOP;  bus_g.COMMAND = CMD_NOP;
        bus_w.INDEX   = '0;       bus_g.INDEX   = '0;
        bus_w.I_DATA  = '0;       bus_g.I_DATA  = '0;

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);

        // fill, then read every depth
        for (int i = 1; i <= 5; i++) drive(0, 1, 0, i);
        for (int i = 0; i < 5; i++)  drive(0, 3, i, 0);
        // push into a full stack
        drive(0, 1, 0, 6);
        drive(0, 3, 0, 0);
        drive(0, 3, 4, 0);

        // drain past empty
        drive(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) drive(0, 1, 0, i);
        for (int i = 0; i < 6; i++)  drive(0, 2, 0, 0);

        // reset colliding with a push
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 2);
        drive(0, 1, 0, 3);
        drive(1, 1, 0, 7);
        drive(0, 2, 0, 0);

        // GET beyond occupancy and out-of-range INDEX
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 9);
        drive(0, 1, 0, 10);
        drive(0, 3, 3, 0);
        drive(0, 3, 1, 0);
        drive(0, 3, 6, 0);
        drive(0, 3, 7, 0);
        drive(0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 79) == 0) ? 1 : 0;
            sel = $urandom_range(0, 9);
            cmd = (sel < 4) ? 1 : (sel < 7) ? 2 : (sel < 9) ? 3 : 0;
            drive(r[0], cmd, $urandom_range(0, 7), $urandom_range(0, 15));
        end

        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        n_checks++;
        if (q_w.size() != 0 || q_g.size() != 0) begin
            $display("FAIL drain got wrap_left=%0d guard_left=%0d want 0/0",
                     q_w.size(), q_g.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
